// File: rtl/cache_module_if.sv
// Command/response bundle between the L1-side requester and the L2 tag controller.
interface cache_module_if;
   logic        cmd_valid;
   logic [3:0]  cmd;
   logic [31:0] addr;
   logic [1:0]  snoop_in;
   logic        resp_valid;
   logic        hit;
   logic [2:0]  bus_op;
   logic [31:0] bus_addr;
   logic        wb_valid;
   logic [31:0] wb_addr;
   logic [1:0]  snoop_out;
   logic        l1_inv;
   logic [31:0] l1_addr;
   logic [31:0] hit_count;
   logic [31:0] read_count;
   logic [31:0] write_count;

   modport master (
      output cmd_valid, cmd, addr, snoop_in,
      input  resp_valid, hit, bus_op, bus_addr, wb_valid, wb_addr, snoop_out,
             l1_inv, l1_addr, hit_count, read_count, write_count
   );

   modport slave (
      input  cmd_valid, cmd, addr, snoop_in,
      output resp_valid, hit, bus_op, bus_addr, wb_valid, wb_addr, snoop_out,
             l1_inv, l1_addr, hit_count, read_count, write_count
   );
endinterface

// File: rtl/cache_module.sv
// MESI tag/state array and controller for an 8-way set-associative L2 (no data), tree PLRU.
// Responses registered one cycle after the command; no backpressure, every command accepted.
module cache_module #(
   parameter int ADDR_W   = 32,
   parameter int OFFSET_W = 6,
   parameter int INDEX_W  = 6,
   parameter int WAYS     = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   cache_module_if.slave bus
);
   localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
   localparam int SETS  = 1 << INDEX_W;
   localparam int WAY_W = 3;

   typedef enum logic [1:0] {ST_I, ST_S, ST_E, ST_M} mesi_t;

   localparam logic [3:0] CMD_DRD  = 4'd0;
   localparam logic [3:0] CMD_DWR  = 4'd1;
   localparam logic [3:0] CMD_IRD  = 4'd2;
   localparam logic [3:0] CMD_SINV = 4'd3;
   localparam logic [3:0] CMD_SRD  = 4'd4;
   localparam logic [3:0] CMD_SWR  = 4'd5;
   localparam logic [3:0] CMD_SRFO = 4'd6;
   localparam logic [3:0] CMD_CLR  = 4'd8;

   localparam logic [2:0] BUS_NONE = 3'd0;
   localparam logic [2:0] BUS_READ = 3'd1;
   localparam logic [2:0] BUS_INV  = 3'd3;
   localparam logic [2:0] BUS_RFO  = 3'd4;

   localparam logic [1:0] SNP_HIT   = 2'b00;
   localparam logic [1:0] SNP_HITM  = 2'b01;
   localparam logic [1:0] SNP_NOHIT = 2'b10;

   logic [TAG_W-1:0] tag_q  [SETS][WAYS];
   mesi_t            st_q   [SETS][WAYS];
   logic [6:0]       plru_q [SETS];

   logic [TAG_W-1:0]   req_tag;
   logic [INDEX_W-1:0] req_idx;
   logic [ADDR_W-1:0]  line_addr, vic_addr;
   logic               hit_any, free_any;
   logic [WAY_W-1:0]   hit_way, free_way, vic_way, sel_way;
   logic [6:0]         cur_plru, plru_nxt;
   mesi_t              cur_st;
   logic               v2, v1, v0;
   logic               unused_addr;

   assign req_tag     = bus.addr[ADDR_W-1 -: TAG_W];
   assign req_idx     = bus.addr[OFFSET_W +: INDEX_W];
   assign line_addr   = {req_tag, req_idx, {OFFSET_W{1'b0}}};
   assign unused_addr = ^{bus.addr[OFFSET_W-1:0], bus.snoop_in[0]};

   always_comb begin
      hit_any  = 1'b0;
      hit_way  = '0;
      free_any = 1'b0;
      free_way = '0;
      // descending scan so the lowest-numbered free way wins
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (st_q[req_idx][w] != ST_I) begin
            if (tag_q[req_idx][w] == req_tag) begin
               hit_any = 1'b1;
               hit_way = WAY_W'(w);
            end
         end else begin
            free_any = 1'b1;
            free_way = WAY_W'(w);
         end
      end
   end

   assign cur_plru = plru_q[req_idx];
   assign v2       = cur_plru[0];
   assign v1       = v2 ? cur_plru[2] : cur_plru[1];
   assign v0       = cur_plru[3'd3 + {1'b0, v2, v1}];
   assign vic_way  = {v2, v1, v0};
   assign sel_way  = hit_any ? hit_way : (free_any ? free_way : vic_way);
   assign cur_st   = st_q[req_idx][sel_way];
   assign vic_addr = {tag_q[req_idx][sel_way], req_idx, {OFFSET_W{1'b0}}};

   // each node on the path points away from the touched way
   always_comb begin
      plru_nxt = cur_plru;
      plru_nxt[0] = ~sel_way[2];
      plru_nxt[3'd1 + {2'b0, sel_way[2]}] = ~sel_way[1];
      plru_nxt[3'd3 + {1'b0, sel_way[2:1]}] = ~sel_way[0];
   end

   logic        d_hit, d_wb_vld, d_l1_inv;
   logic [2:0]  d_bus_op;
   logic [1:0]  d_snoop;
   logic [31:0] d_bus_addr, d_wb_addr, d_l1_addr;
   logic        wr_en, touch, clr, inc_hit, inc_rd, inc_wr;
   mesi_t       wr_st;

   always_comb begin
      d_hit      = 1'b0;
      d_bus_op   = BUS_NONE;
      d_bus_addr = '0;
      d_wb_vld   = 1'b0;
      d_wb_addr  = '0;
      d_snoop    = SNP_NOHIT;
      d_l1_inv   = 1'b0;
      d_l1_addr  = '0;
      wr_en      = 1'b0;
      wr_st      = ST_I;
      touch      = 1'b0;
      clr        = 1'b0;
      inc_hit    = 1'b0;
      inc_rd     = 1'b0;
      inc_wr     = 1'b0;
      if (bus.cmd_valid) begin
         case (bus.cmd)
            CMD_DRD, CMD_IRD, CMD_DWR: begin
               d_hit   = hit_any;
               inc_hit = hit_any;
               touch   = 1'b1;
               inc_rd  = (bus.cmd != CMD_DWR);
               inc_wr  = (bus.cmd == CMD_DWR);
               if (!hit_any && !free_any) begin
                  d_l1_inv  = 1'b1;
                  d_l1_addr = vic_addr;
                  if (cur_st == ST_M) begin
                     d_wb_vld  = 1'b1;
                     d_wb_addr = vic_addr;
                  end
               end
               if (bus.cmd == CMD_DWR) begin
                  wr_en = 1'b1;
                  wr_st = ST_M;
                  if (!hit_any) begin
                     d_bus_op   = BUS_RFO;
                     d_bus_addr = line_addr;
                  end else if (cur_st == ST_S) begin
                     d_bus_op   = BUS_INV;
                     d_bus_addr = line_addr;
                  end
               end else if (!hit_any) begin
                  wr_en      = 1'b1;
                  wr_st      = bus.snoop_in[1] ? ST_E : ST_S;
                  d_bus_op   = BUS_READ;
                  d_bus_addr = line_addr;
               end
            end
            CMD_SINV: begin
               d_hit = hit_any;
               if (hit_any && cur_st == ST_S) begin
                  d_snoop   = SNP_HIT;
                  wr_en     = 1'b1;
                  wr_st     = ST_I;
                  d_l1_inv  = 1'b1;
                  d_l1_addr = line_addr;
               end
            end
            CMD_SRD: begin
               d_hit = hit_any;
               if (hit_any) begin
                  wr_en = 1'b1;
                  wr_st = ST_S;
                  if (cur_st == ST_M) begin
                     d_snoop   = SNP_HITM;
                     d_wb_vld  = 1'b1;
                     d_wb_addr = line_addr;
                  end else begin
                     d_snoop = SNP_HIT;
                  end
               end
            end
            CMD_SWR: d_hit = hit_any;
            CMD_SRFO: begin
               d_hit = hit_any;
               if (hit_any) begin
                  wr_en     = 1'b1;
                  wr_st     = ST_I;
                  d_l1_inv  = 1'b1;
                  d_l1_addr = line_addr;
                  if (cur_st == ST_M) begin
                     d_snoop   = SNP_HITM;
                     d_wb_vld  = 1'b1;
                     d_wb_addr = line_addr;
                  end else begin
                     d_snoop = SNP_HIT;
                  end
               end
            end
            CMD_CLR: clr = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SETS; s++) begin
            plru_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               tag_q[s][w] <= '0;
               st_q[s][w]  <= ST_I;
            end
         end
      end else if (clr) begin
         for (int s = 0; s < SETS; s++) begin
            plru_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) st_q[s][w] <= ST_I;
         end
      end else begin
         if (wr_en) begin
            tag_q[req_idx][sel_way] <= req_tag;
            st_q[req_idx][sel_way]  <= wr_st;
         end
         if (touch) plru_q[req_idx] <= plru_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.resp_valid  <= 1'b0;
         bus.hit         <= 1'b0;
         bus.bus_op      <= BUS_NONE;
         bus.bus_addr    <= '0;
         bus.wb_valid    <= 1'b0;
         bus.wb_addr     <= '0;
         bus.snoop_out   <= SNP_NOHIT;
         bus.l1_inv      <= 1'b0;
         bus.l1_addr     <= '0;
         bus.hit_count   <= '0;
         bus.read_count  <= '0;
         bus.write_count <= '0;
      end else begin
         bus.resp_valid <= bus.cmd_valid;
         bus.hit        <= d_hit;
         bus.bus_op     <= d_bus_op;
         bus.bus_addr   <= d_bus_addr;
         bus.wb_valid   <= d_wb_vld;
         bus.wb_addr    <= d_wb_addr;
         bus.snoop_out  <= d_snoop;
         bus.l1_inv     <= d_l1_inv;
         bus.l1_addr    <= d_l1_addr;
         if (clr) begin
            bus.hit_count   <= '0;
            bus.read_count  <= '0;
            bus.write_count <= '0;
         end else begin
            bus.hit_count   <= bus.hit_count + {31'd0, inc_hit};
            bus.read_count  <= bus.read_count + {31'd0, inc_rd};
            bus.write_count <= bus.write_count + {31'd0, inc_wr};
         end
      end
   end
endmodule

// File: tb/tb_cache_module.sv
// Randomized bench for cache_module against a set/way/PLRU-tree reference model.
module tb_cache_module;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   cache_module_if bus();
   cache_module dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_chk = 0;
   int n_err = 0;

   // model: state 0=I 1=S 2=E 3=M
   int          m_st   [64][8];
   logic [19:0] m_tag  [64][8];
   bit          m_plru [64][7];
   logic [31:0] m_hits, m_rds, m_wrs;

   logic        e_hit, e_wb, e_inv;
   logic [2:0]  e_bus;
   logic [1:0]  e_snp;
   logic [31:0] e_baddr, e_waddr, e_iaddr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < 64; s++) begin
         for (int w = 0; w < 8; w++) m_st[s][w] = 0;
         for (int n = 0; n < 7; n++) m_plru[s][n] = 1'b0;
      end
      m_hits = 0; m_rds = 0; m_wrs = 0;
   endtask

   task automatic touch(input int idx, input int w);
      int node = 0;
      for (int lvl = 0; lvl < 3; lvl++) begin
         int b = (w >> (2 - lvl)) & 1;
         m_plru[idx][node] = (b == 0);
         node = 2 * node + 1 + b;
      end
   endtask

   function automatic int victim(input int idx);
      int node = 0;
      int w = 0;
      for (int lvl = 0; lvl < 3; lvl++) begin
         int b = int'(m_plru[idx][node]);
         w = 2 * w + b;
         node = 2 * node + 1 + b;
      end
      return w;
   endfunction

   task automatic fill(input int idx, output int w);
      w = -1;
      for (int i = 7; i >= 0; i--) if (m_st[idx][i] == 0) w = i;
      if (w < 0) begin
         w = victim(idx);
         e_inv = 1'b1;
         e_iaddr = {m_tag[idx][w], 6'(idx), 6'd0};
         if (m_st[idx][w] == 3) begin
            e_wb = 1'b1;
            e_waddr = e_iaddr;
         end
      end
   endtask

   task automatic model(input logic [3:0] c, input logic [31:0] a, input logic [1:0] s);
      int idx, hw, fw;
      logic [19:0] t;
      logic [31:0] la;
      idx = int'(a[11:6]); t = a[31:12]; la = {a[31:6], 6'd0}; hw = -1;
      e_hit = 0; e_wb = 0; e_inv = 0; e_bus = 0; e_snp = 2'b10;
      e_baddr = 0; e_waddr = 0; e_iaddr = 0;
      for (int w = 0; w < 8; w++) if (m_st[idx][w] != 0 && m_tag[idx][w] == t) hw = w;
      if (c <= 6) e_hit = (hw >= 0);
      case (c)
         4'd0, 4'd2: begin
            m_rds++;
            if (hw >= 0) begin m_hits++; touch(idx, hw); end
            else begin
               fill(idx, fw);
               m_tag[idx][fw] = t; m_st[idx][fw] = s[1] ? 2 : 1;
               e_bus = 1; e_baddr = la; touch(idx, fw);
            end
         end
         4'd1: begin
            m_wrs++;
            if (hw >= 0) begin
               m_hits++;
               if (m_st[idx][hw] == 1) begin e_bus = 3; e_baddr = la; end
               m_st[idx][hw] = 3; touch(idx, hw);
            end else begin
               fill(idx, fw);
               m_tag[idx][fw] = t; m_st[idx][fw] = 3;
               e_bus = 4; e_baddr = la; touch(idx, fw);
            end
         end
         4'd3: if (hw >= 0 && m_st[idx][hw] == 1) begin
            m_st[idx][hw] = 0; e_snp = 2'b00; e_inv = 1; e_iaddr = la;
         end
         4'd4: if (hw >= 0) begin
            if (m_st[idx][hw] == 3) begin e_snp = 2'b01; e_wb = 1; e_waddr = la; end
            else e_snp = 2'b00;
            m_st[idx][hw] = 1;
         end
         4'd6: if (hw >= 0) begin
            if (m_st[idx][hw] == 3) begin e_snp = 2'b01; e_wb = 1; e_waddr = la; end
            else e_snp = 2'b00;
            m_st[idx][hw] = 0; e_inv = 1; e_iaddr = la;
         end
         4'd8: model_reset();
         default: ;
      endcase
   endtask

   task automatic check_resp(input string p);
      chk({p, ".resp_valid"}, 32'(bus.resp_valid), 32'd1);
      chk({p, ".hit"}, 32'(bus.hit), 32'(e_hit));
      chk({p, ".bus_op"}, 32'(bus.bus_op), 32'(e_bus));
      chk({p, ".bus_addr"}, bus.bus_addr, e_baddr);
      chk({p, ".wb_valid"}, 32'(bus.wb_valid), 32'(e_wb));
      chk({p, ".wb_addr"}, bus.wb_addr, e_waddr);
      chk({p, ".snoop_out"}, 32'(bus.snoop_out), 32'(e_snp));
      chk({p, ".l1_inv"}, 32'(bus.l1_inv), 32'(e_inv));
      chk({p, ".l1_addr"}, bus.l1_addr, e_iaddr);
      chk({p, ".hit_count"}, bus.hit_count, m_hits);
      chk({p, ".read_count"}, bus.read_count, m_rds);
      chk({p, ".write_count"}, bus.write_count, m_wrs);
   endtask

   task automatic check_quiet(input string p);
      chk({p, ".resp_valid"}, 32'(bus.resp_valid), 32'd0);
      chk({p, ".hit"}, 32'(bus.hit), 32'd0);
      chk({p, ".bus_op"}, 32'(bus.bus_op), 32'd0);
      chk({p, ".bus_addr"}, bus.bus_addr, 32'd0);
      chk({p, ".wb_valid"}, 32'(bus.wb_valid), 32'd0);
      chk({p, ".wb_addr"}, bus.wb_addr, 32'd0);
      chk({p, ".snoop_out"}, 32'(bus.snoop_out), 32'd2);
      chk({p, ".l1_inv"}, 32'(bus.l1_inv), 32'd0);
      chk({p, ".l1_addr"}, bus.l1_addr, 32'd0);
   endtask

   // called at a negedge; returns at the negedge where the response is visible
   task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [1:0] s);
      bus.cmd_valid = 1'b1; bus.cmd = c; bus.addr = a; bus.snoop_in = s;
      model(c, a, s);
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0; bus.cmd = 4'($urandom); bus.addr = $urandom; bus.snoop_in = 2'($urandom);
      check_resp($sformatf("c%0d@%h", c, a));
   endtask

   task automatic idle();
      @(posedge clk);
      @(negedge clk);
      check_quiet("idle");
   endtask

   task automatic reset_mid();
      bus.cmd_valid = 1'b1; bus.cmd = 4'd0; bus.addr = 32'h0000_1040; bus.snoop_in = 2'b10;
      @(posedge clk);
      #1;
      chk("pre_rst.resp_valid", 32'(bus.resp_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check_quiet("mid_rst");
      chk("mid_rst.hit_count", bus.hit_count, 32'd0);
      chk("mid_rst.read_count", bus.read_count, 32'd0);
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      rst_n = 1'b1;
      model_reset();
      idle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      bus.cmd_valid = 1'b0; bus.cmd = '0; bus.addr = '0; bus.snoop_in = 2'b10;
      model_reset();
      @(negedge clk); @(negedge clk);
      check_quiet("reset");
      chk("reset.hit_count", bus.hit_count, 32'd0);
      chk("reset.write_count", bus.write_count, 32'd0);
      rst_n = 1'b1;
      idle();

      issue(4'd0, 32'h0000_1040, 2'b10);
      chk("rd_miss.bus_op", 32'(bus.bus_op), 32'd1);
      issue(4'd0, 32'h0000_1040, 2'b10);
      chk("rd_hit.hit", 32'(bus.hit), 32'd1);
      chk("rd_hit.read_count", bus.read_count, 32'd2);

      issue(4'd0, 32'h0000_2040, 2'b00);
      issue(4'd1, 32'h0000_2040, 2'b10);
      chk("wr_s.bus_op", 32'(bus.bus_op), 32'd3);
      issue(4'd4, 32'h0000_2040, 2'b10);
      chk("snp_rd_m.snoop_out", 32'(bus.snoop_out), 32'd1);
      chk("snp_rd_m.wb_valid", 32'(bus.wb_valid), 32'd1);

      issue(4'd8, 32'h0, 2'b10);
      for (int t = 0; t < 9; t++) issue(4'd0, (t << 12) | 32'h40, 2'b10);
      chk("evict0.l1_addr", bus.l1_addr, 32'h0000_0040);
      chk("evict0.wb_valid", 32'(bus.wb_valid), 32'd0);

      issue(4'd1, 32'h0000_3080, 2'b10);
      chk("wr_miss.bus_op", 32'(bus.bus_op), 32'd4);
      for (int t = 4; t < 12; t++) issue(4'd0, (t << 12) | 32'h80, 2'b10);
      chk("evict_m.wb_addr", bus.wb_addr, 32'h0000_3080);

      issue(4'd0, 32'h5000_00C0, 2'b11);
      issue(4'd6, 32'h5000_00C0, 2'b10);
      chk("rfo_e.snoop_out", 32'(bus.snoop_out), 32'd0);
      issue(4'd0, 32'h5000_00C0, 2'b10);
      chk("after_rfo.hit", 32'(bus.hit), 32'd0);
      issue(4'd5, 32'h0000_1040, 2'b10);
      chk("snp_wr.snoop_out", 32'(bus.snoop_out), 32'd2);

      issue(4'd8, 32'h0, 2'b10);
      chk("clear.hit_count", bus.hit_count, 32'd0);
      issue(4'd0, 32'h0000_1040, 2'b10);
      chk("clear.miss", 32'(bus.hit), 32'd0);

      reset_mid();

      for (int i = 0; i < 3000; i++) begin
         int r;
         logic [3:0] c;
         logic [19:0] t;
         logic [5:0] ix;
         r = $urandom_range(0, 99);
         if (r < 25) c = 4'd0;
         else if (r < 40) c = 4'd1;
         else if (r < 50) c = 4'd2;
         else if (r < 58) c = 4'd3;
         else if (r < 68) c = 4'd4;
         else if (r < 74) c = 4'd5;
         else if (r < 84) c = 4'd6;
         else if (r < 86) c = 4'd9;
         else if (r < 88) c = 4'($urandom_range(10, 15));
         else if (r < 89) c = 4'd8;
         else c = 4'd0;
         t = 20'($urandom_range(0, 11)) * 20'h11111;
         ix = 6'($urandom_range(1, 3));
         issue(c, {t, ix, 6'($urandom)}, 2'($urandom));
         if ($urandom_range(0, 7) == 0) idle();
         if (i == 1500) reset_mid();
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
